spi_adc_target: RTL and testbench
=================================

Name: spi_adc_target

Overview:
- SPI target (responder) that terminates the 16-bit housekeeping SPI frames sent by the ADC-config SPI master.
- Decodes each frame into a read or write of a small register bank. Serves as the ADC register-model for system simulation and as the on-board target for daisy-chained configuration.
- SPI pins are oversampled in the single system clock domain. No SPI-clocked logic.

Parameters:
- NREG, 8: number of 8-bit registers. Legal range 1..128.
- SYNC_STG, 2: synchronizer flops on spi_cs_i, spi_clk_i, spi_mosi_i.
- CNT_W, 8: width of the saturating frame-error counter.

Ports:
- clk_i  in  1  system clock. Must be at least 8x the SPI clock.
- rst_i  in  1  reset, synchronous, active-high.
- spi_cs_i  in  1  chip select, active low.
- spi_clk_i  in  1  SPI clock. Idles high (CPOL=1).
- spi_mosi_i  in  1  serial data in, MSB first.
- spi_miso_o  out  1  serial data out.
- spi_miso_t  out  1  MISO tristate: 1 = high-Z.
- reg_o  out  NREG*8  flat register bank. Register n is reg_o[8n+7:8n].
- wr_stb_o  out  1  one-cycle pulse when a write commits.
- wr_adr_o  out  7  address of the last committed write.
- frm_err_o  out  CNT_W  saturating count of bad frames.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Frame format (16 bits, MSB first): bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = data.
- SPI mode: master drives data on falling SCLK edges; data is sampled on rising edges. The target samples MOSI at synchronized rising edges and drives MISO at synchronized falling edges.
- Edge detection: compare the last two synchronized SCLK samples. CS is considered asserted only after synchronization.
- State machine: IDLE, HDR, DATA, ERR.
  - IDLE -> HDR on synchronized CS falling edge. Bit counter cleared.
  - HDR: shift 8 bits. After the 8th rising edge, latch R/W and address.
    - Address >= NREG: go to ERR and increment frm_err_o.
    - Otherwise go to DATA. For a read, the selected register is loaded into the TX shifter.
  - DATA (read): on each falling edge, drive the TX shifter MSB on spi_miso_o and shift. The first falling edge after the 8th rising edge drives data bit7.
  - DATA (write): shift 8 bits from MOSI. On the 16th rising edge, the write commits. reg[adr], wr_adr_o and wr_stb_o update in the cycle after that edge is detected.
  - DATA, more rising edges after bit 16 and before CS rises: go to ERR and increment frm_err_o. The committed write stays committed.
  - ERR: ignore SCLK until CS rises, then go to IDLE.
  - CS rises in HDR or DATA before 16 bits: abort, no register change, increment frm_err_o, go to IDLE.
- spi_miso_t is 0 only in DATA with R/W=1; otherwise 1. spi_miso_o is 0 whenever spi_miso_t=1.
- busy_o is 1 in HDR, DATA and ERR.
- frm_err_o saturates at all-ones and never wraps.
- Reset values: reg_o=0, wr_stb_o=0, wr_adr_o=0, frm_err_o=0, busy_o=0, spi_miso_o=0, spi_miso_t=1, state IDLE. A reset mid-frame discards the frame with no error count. The frame is re-acquired only at the next CS falling edge.
- CS asserted while rst_i releases: stay in IDLE until CS goes high and then falls again.

Optional Feature:
- Macro SPI_ADC_TARGET_READ_EN.
- Defined: read frames behave as above.
- Undefined: read frames are treated as bad frames. Go to ERR after the header, increment frm_err_o. spi_miso_t is held at 1 and spi_miso_o at 0, and the TX shifter is not synthesized.

Decomposition:
- Shared package spi_adc_pkg holds:
  - state encoding localparams (IDLE=2'd0, HDR=2'd1, DATA=2'd2, ERR=2'd3);
  - frame field positions (RW_BIT=15, ADR_MSB=14, ADR_LSB=8, DAT_W=8, FRM_LEN=16);
  - the ADC register address constants shared with the master (PDWN=1, TIM=2, MODE=3, FORM=4).
- One sub-module, spi_pin_sync: SYNC_STG-deep synchronizer plus rise/fall edge detect, instantiated for SCLK and CS. MOSI uses only its synchronizer.

Test Plan:
- Writes: frames 0x0100, 0x0201, 0x0302, 0x0400 at 12.5 MHz SCLK, 125 MHz clk -> reg1=0x00, reg2=0x01, reg3=0x02, reg4=0x00. Four wr_stb_o pulses with wr_adr_o 1, 2, 3, 4. frm_err_o=0.
- Readback (READ_EN defined): write 0x05A5, then read frame 0x8500 -> MISO bits 0xA5, sampled on rising edges 9..16. spi_miso_t low only during the data phase. reg5 unchanged.
- Bad address: frame 0x0A33 with NREG=8 -> no write, frm_err_o=1, MISO stays high-Z.
- Aborted frame: CS deasserted after 11 bits of 0x0277 -> reg2 keeps its prior value, no wr_stb_o, frm_err_o increments by 1. A following valid frame works.
- Overlong frame and reset: a 20-bit frame whose first 16 bits are 0x0311 -> reg3=0x11 and frm_err_o increments. rst_i pulsed mid-frame at bit 6 -> all outputs at reset values, remainder of that frame ignored, next frame decoded.
- Saturation: 300 aborted frames with CNT_W=8 -> frm_err_o=255 and stays there.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// Shared constants for the ADC housekeeping SPI target: state encoding,
// frame field positions and the ADC register map shared with the master.
package spi_adc_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      HDR  = ST_HDR,
      DATA = ST_DATA,
      ERR  = ST_ERR
   } state_e;

   localparam int RW_BIT  = 15;
   localparam int ADR_MSB = 14;
   localparam int ADR_LSB = 8;
   localparam int DAT_W   = 8;
   localparam int FRM_LEN = 16;
   localparam int ADR_W   = ADR_MSB - ADR_LSB + 1;

   localparam logic [ADR_W-1:0] PDWN = 7'd1;
   localparam logic [ADR_W-1:0] TIM  = 7'd2;
   localparam logic [ADR_W-1:0] MODE = 7'd3;
   localparam logic [ADR_W-1:0] FORM = 7'd4;

endpackage

// File: rtl/spi_adc_target_if.sv
// SPI pin bundle between the config master and the ADC target.
// Ports: cs (active low), sclk (CPOL=1), mosi, miso, miso_t (1 = high-Z).
interface spi_adc_target_if;

   logic spi_cs_i;
   logic spi_clk_i;
   logic spi_mosi_i;
   logic spi_miso_o;
   logic spi_miso_t;

   modport master (
      output spi_cs_i, spi_clk_i, spi_mosi_i,
      input  spi_miso_o, spi_miso_t
   );

   modport slave (
      input  spi_cs_i, spi_clk_i, spi_mosi_i,
      output spi_miso_o, spi_miso_t
   );

endinterface

// File: rtl/spi_pin_sync.sv
// STG-deep pin synchronizer with rise/fall detect on the synchronized level.
// Ports: clk_i, rst_i (sync, high), d_i async pin, q_o level, rise_o, fall_o.
module spi_pin_sync #(
   parameter int   STG     = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STG-1:0] sync_q;
   logic           prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STG{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= STG'({sync_q, d_i});
         prev_q <= sync_q[STG-1];
      end
   end

   assign q_o    = sync_q[STG-1];
   assign rise_o = sync_q[STG-1] & ~prev_q;
   assign fall_o = ~sync_q[STG-1] & prev_q;

endmodule

// File: rtl/spi_adc_target.sv
// SPI target decoding 16-bit R/W frames into an NREG x 8-bit register bank.
// Ports: clk_i, rst_i (sync, high), spi (slave modport), reg_o flat bank,
// wr_stb_o/wr_adr_o write commit, frm_err_o saturating error count, busy_o.
// Build option: SPI_ADC_TARGET_READ_EN enables read frames and MISO drive.
module spi_adc_target
   import spi_adc_pkg::*;
#(
   parameter int NREG     = 8,
   parameter int SYNC_STG = 2,
   parameter int CNT_W    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   spi_adc_target_if.slave       spi,
   output logic [NREG*8-1:0]     reg_o,
   output logic                  wr_stb_o,
   output logic [ADR_W-1:0]      wr_adr_o,
   output logic [CNT_W-1:0]      frm_err_o,
   output logic                  busy_o
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int BW = $clog2(FRM_LEN + 1);

   logic clk_rise, clk_fall, cs_rise, cs_fall, mosi;
   logic unused_cs_lvl, unused_clk_lvl, unused_mosi_r, unused_mosi_f;

   // CS resets to "asserted" so a CS already low at reset release
   // produces no falling edge; a new frame needs CS high then low.
   spi_pin_sync #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_cs (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(spi.spi_cs_i),
      .q_o(unused_cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_pin_sync #(.STG(SYNC_STG), .RST_VAL(1'b1)) u_clk (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(spi.spi_clk_i),
      .q_o(unused_clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
   );

   spi_pin_sync #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(spi.spi_mosi_i),
      .q_o(mosi), .rise_o(unused_mosi_r), .fall_o(unused_mosi_f)
   );

   state_e               state_q;
   logic [BW-1:0]        bit_q;
   logic [DAT_W-2:0]     sh_q;
   logic [ADR_W-1:0]     adr_q;
   logic [DAT_W-1:0]     regs_q [NREG];
   logic                 wr_stb_q;
   logic [ADR_W-1:0]     wr_adr_q;
   logic [CNT_W-1:0]     err_q;
   logic                 busy_q;

   // byte_w is the byte completed by the current rising edge
   logic [DAT_W-1:0]     byte_w;
   logic [ADR_W-1:0]     hdr_adr;
   logic                 hdr_rw;
   logic                 adr_ok;
   logic                 wr_frm;

   assign byte_w  = {sh_q, mosi};
   assign hdr_rw  = byte_w[RW_BIT-DAT_W];
   assign hdr_adr = byte_w[ADR_MSB-DAT_W:ADR_LSB-DAT_W];
   assign adr_ok  = (32'(hdr_adr) < NREG);

`ifdef SPI_ADC_TARGET_READ_EN
   logic             rw_q;
   logic             miso_q;
   logic             miso_t_q;
   logic [DAT_W-1:0] tx_q;
   assign wr_frm         = ~rw_q;
   assign spi.spi_miso_o = miso_q;
   assign spi.spi_miso_t = miso_t_q;
`else
   logic unused_clk_fall;
   assign unused_clk_fall = clk_fall;
   assign wr_frm          = 1'b1;
   assign spi.spi_miso_o  = 1'b0;
   assign spi.spi_miso_t  = 1'b1;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         bit_q    <= '0;
         sh_q     <= '0;
         adr_q    <= '0;
         wr_stb_q <= 1'b0;
         wr_adr_q <= '0;
         err_q    <= '0;
         busy_q   <= 1'b0;
         for (int n = 0; n < NREG; n++) regs_q[n] <= '0;
`ifdef SPI_ADC_TARGET_READ_EN
         rw_q     <= 1'b0;
         tx_q     <= '0;
         miso_q   <= 1'b0;
         miso_t_q <= 1'b1;
`endif
      end else begin
         wr_stb_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q <= HDR;
                  bit_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            HDR: begin
               if (cs_rise) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  err_q   <= sat_inc(err_q);
               end else if (clk_rise) begin
                  sh_q  <= byte_w[DAT_W-2:0];
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == BW'(DAT_W - 1)) begin
                     adr_q <= hdr_adr;
                     if (!adr_ok) begin
                        state_q <= ERR;
                        err_q   <= sat_inc(err_q);
                     end else if (hdr_rw) begin
`ifdef SPI_ADC_TARGET_READ_EN
                        state_q  <= DATA;
                        rw_q     <= 1'b1;
                        tx_q     <= regs_q[hdr_adr[AW-1:0]];
                        miso_t_q <= 1'b0;
`else
                        state_q <= ERR;
                        err_q   <= sat_inc(err_q);
`endif
                     end else begin
                        state_q <= DATA;
`ifdef SPI_ADC_TARGET_READ_EN
                        rw_q    <= 1'b0;
`endif
                     end
                  end
               end
            end
            DATA: begin
               if (cs_rise) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (bit_q != BW'(FRM_LEN)) err_q <= sat_inc(err_q);
`ifdef SPI_ADC_TARGET_READ_EN
                  miso_q   <= 1'b0;
                  miso_t_q <= 1'b1;
`endif
               end else if (clk_rise) begin
                  if (bit_q == BW'(FRM_LEN)) begin
                     // overlong frame: a write already committed stays
                     state_q <= ERR;
                     err_q   <= sat_inc(err_q);
`ifdef SPI_ADC_TARGET_READ_EN
                     miso_q   <= 1'b0;
                     miso_t_q <= 1'b1;
`endif
                  end else begin
                     sh_q  <= byte_w[DAT_W-2:0];
                     bit_q <= bit_q + 1'b1;
                     if (bit_q == BW'(FRM_LEN - 1) && wr_frm) begin
                        regs_q[adr_q[AW-1:0]] <= byte_w;
                        wr_stb_q <= 1'b1;
                        wr_adr_q <= adr_q;
                     end
                  end
               end
`ifdef SPI_ADC_TARGET_READ_EN
               else if (clk_fall && rw_q && bit_q != BW'(FRM_LEN)) begin
                  miso_q <= tx_q[DAT_W-1];
                  tx_q   <= {tx_q[DAT_W-2:0], 1'b0};
               end
`endif
            end
            ERR: begin
               if (cs_rise) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   for (genvar n = 0; n < NREG; n++) begin : g_reg
      assign reg_o[8*n +: 8] = regs_q[n];
   end

   assign wr_stb_o  = wr_stb_q;
   assign wr_adr_o  = wr_adr_q;
   assign frm_err_o = err_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_spi_adc_target.sv
// Bench for spi_adc_target: table of write/bad/abort/overlong frames plus
// read, mid-frame reset and error-counter saturation sequences.
module tb_spi_adc_target;

   localparam int NREG  = 8;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #4 clk = ~clk;

   spi_adc_target_if bus();

   logic [NREG*8-1:0] reg_o;
   logic              wr_stb;
   logic [6:0]        wr_adr;
   logic [CNT_W-1:0]  frm_err;
   logic              busy;

   spi_adc_target #(.NREG(NREG), .SYNC_STG(2), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .spi(bus),
      .reg_o(reg_o), .wr_stb_o(wr_stb), .wr_adr_o(wr_adr),
      .frm_err_o(frm_err), .busy_o(busy)
   );

   typedef struct {
      logic [15:0] frm;
      int          nb;
      int          idx;
      logic [7:0]  val;
      logic [7:0]  err;
      bit          stb;
   } vec_t;

   typedef struct {
      logic [6:0] adr;
      logic [7:0] dat;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_tests = 0;
   int  n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rbyte(input int n);
      return reg_o[8*n +: 8];
   endfunction

   // scoreboard: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (!rst && wr_stb) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_stb_unexpected: adr %0d, expected no write",
                     wr_adr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_wr_adr", 32'(wr_adr), 32'(mon_e.adr));
            chk("sb_wr_dat", 32'(rbyte(int'(mon_e.adr))), 32'(mon_e.dat));
         end
      end
   end

   task automatic bit_cyc(input logic b);
      bus.spi_clk_i  = 1'b0;
      bus.spi_mosi_i = b;
      #40;
      bus.spi_clk_i  = 1'b1;
      #40;
   endtask

   task automatic send_frame(input logic [15:0] f, input int nb,
                             output logic [7:0] rx, output int mt_hdr,
                             output int mt_dat, output logic bz);
      rx     = '0;
      mt_hdr = 0;
      mt_dat = 0;
      bz     = 1'b0;
      bus.spi_cs_i = 1'b0;
      #60;
      for (int i = 0; i < nb; i++) begin
         bus.spi_clk_i  = 1'b0;
         bus.spi_mosi_i = (i < 16) ? f[15-i] : 1'b0;
         #40;
         if (i < 8) begin
            if (bus.spi_miso_t === 1'b0) mt_hdr++;
         end else if (i < 16) begin
            if (bus.spi_miso_t === 1'b0) mt_dat++;
            rx = {rx[6:0], bus.spi_miso_o};
         end
         if (i == 4) bz = busy;
         bus.spi_clk_i = 1'b1;
         #40;
      end
      #40;
      bus.spi_cs_i = 1'b1;
      #200;
   endtask

   initial begin
      vec_t        v[9];
      logic [7:0]  rx;
      int          mh, md;
      logic        bz;
      int          err_model;
      logic [15:0] rf;

      v[0] = '{16'h0100, 16, 1, 8'h00, 8'd0, 1'b1};
      v[1] = '{16'h0201, 16, 2, 8'h01, 8'd0, 1'b1};
      v[2] = '{16'h0302, 16, 3, 8'h02, 8'd0, 1'b1};
      v[3] = '{16'h0400, 16, 4, 8'h00, 8'd0, 1'b1};
      v[4] = '{16'h05A5, 16, 5, 8'hA5, 8'd0, 1'b1};
      v[5] = '{16'h0A33, 16, 3, 8'h02, 8'd1, 1'b0};
      v[6] = '{16'h0277, 11, 2, 8'h01, 8'd2, 1'b0};
      v[7] = '{16'h0255, 16, 2, 8'h55, 8'd2, 1'b1};
      v[8] = '{16'h0311, 20, 3, 8'h11, 8'd3, 1'b1};

      bus.spi_cs_i   = 1'b1;
      bus.spi_clk_i  = 1'b1;
      bus.spi_mosi_i = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      chk("rst_reg",    32'(reg_o != '0), 32'd0);
      chk("rst_stb",    32'(wr_stb), 32'd0);
      chk("rst_adr",    32'(wr_adr), 32'd0);
      chk("rst_err",    32'(frm_err), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_miso",   32'(bus.spi_miso_o), 32'd0);
      chk("rst_miso_t", 32'(bus.spi_miso_t), 32'd1);

      for (int i = 0; i < 9; i++) begin
         if (v[i].stb) exp_q.push_back('{v[i].frm[14:8], v[i].frm[7:0]});
         send_frame(v[i].frm, v[i].nb, rx, mh, md, bz);
         chk($sformatf("v%0d_reg", i), 32'(rbyte(v[i].idx)), 32'(v[i].val));
         chk($sformatf("v%0d_err", i), 32'(frm_err), 32'(v[i].err));
         chk($sformatf("v%0d_sb", i), 32'(exp_q.size()), 32'd0);
         chk($sformatf("v%0d_hiz", i), 32'(mh + md), 32'd0);
         chk($sformatf("v%0d_busy", i), 32'(bz), 32'd1);
         chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      end
      err_model = 3;

`ifdef SPI_ADC_TARGET_READ_EN
      send_frame(16'h8500, 16, rx, mh, md, bz);
      chk("rd_miso",   32'(rx), 32'hA5);
      chk("rd_t_hdr",  32'(mh), 32'd0);
      chk("rd_t_data", 32'(md), 32'd8);
      chk("rd_reg5",   32'(rbyte(5)), 32'hA5);
      chk("rd_err",    32'(frm_err), 32'(err_model));
`else
      send_frame(16'h8500, 16, rx, mh, md, bz);
      err_model++;
      chk("rd_off_err",  32'(frm_err), 32'(err_model));
      chk("rd_off_hiz",  32'(mh + md), 32'd0);
      chk("rd_off_miso", 32'(rx), 32'd0);
      chk("rd_off_reg5", 32'(rbyte(5)), 32'hA5);
`endif
      chk("rd_end_t",    32'(bus.spi_miso_t), 32'd1);
      chk("rd_end_miso", 32'(bus.spi_miso_o), 32'd0);
      chk("rd_sb",       32'(exp_q.size()), 32'd0);

      // reset after 6 bits of a write, then finish clocking that frame
      rf = 16'h0466;
      bus.spi_cs_i = 1'b0;
      #60;
      for (int i = 0; i < 6; i++) bit_cyc(rf[15-i]);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_reg",    32'(reg_o != '0), 32'd0);
      chk("mrst_adr",    32'(wr_adr), 32'd0);
      chk("mrst_err",    32'(frm_err), 32'd0);
      chk("mrst_busy",   32'(busy), 32'd0);
      chk("mrst_miso_t", 32'(bus.spi_miso_t), 32'd1);
      for (int i = 6; i < 16; i++) bit_cyc(rf[15-i]);
      #40;
      bus.spi_cs_i = 1'b1;
      #200;
      chk("mrst_tail_reg4", 32'(rbyte(4)), 32'd0);
      chk("mrst_tail_err",  32'(frm_err), 32'd0);
      chk("mrst_tail_busy", 32'(busy), 32'd0);
      err_model = 0;

      exp_q.push_back('{7'd1, 8'h99});
      send_frame(16'h0199, 16, rx, mh, md, bz);
      chk("post_rst_reg1", 32'(rbyte(1)), 32'h99);
      chk("post_rst_err",  32'(frm_err), 32'(err_model));
      chk("post_rst_sb",   32'(exp_q.size()), 32'd0);

      // aborted frames drive the error counter into saturation
      for (int i = 0; i < 305; i++) begin
         bus.spi_cs_i = 1'b0;
         #60;
         bit_cyc(1'b0);
         #40;
         bus.spi_cs_i = 1'b1;
         #100;
         if (err_model < 255) err_model++;
         if (i == 0 || i == 299 || i == 304)
            chk($sformatf("sat_%0d", i), 32'(frm_err), 32'(err_model));
      end
      chk("sat_reg1", 32'(rbyte(1)), 32'h99);
      chk("sat_sb",   32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
